mul_seq_ctrl: RTL and testbench

//  Iterative shift-add multiply sequencer backing the FMUL function code of the

---
 rtl/mul_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_mul_seq_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiply sequencer for the FMUL function code. Each clock
// adds one partial product, then a sign stage forms the W-bit result and V/C/N/Z.
module mul_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             v,
  output logic             c,
  output logic             n,
  output logic             z
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [PW-1:0] HALF = PW'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q, mplier_q;
  logic [PW-1:0]    acc_q;
  logic             sign_q;
  logic             busy_q, done_q, v_q, c_q, n_q, z_q;
  logic [WIDTH-1:0] result_q;

  // Magnitude fits in WIDTH unsigned bits: |-2^(W-1)| = 2^(W-1).
  logic [WIDTH-1:0] a_mag_d, b_mag_d, s_lo_d;
  logic [PW-1:0]    pp_d;
  logic             v_d;

  always_comb begin
    a_mag_d = (SIGNED && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag_d = (SIGNED && b[WIDTH-1]) ? (~b + 1'b1) : b;
    pp_d    = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
    // Low bits of -P depend only on low bits of P.
    s_lo_d  = sign_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    if (SIGNED) v_d = sign_q ? (acc_q > HALF) : (acc_q > (HALF - 1'b1));
    else        v_d = |acc_q[PW-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            mcand_q  <= a_mag_d;
            mplier_q <= b_mag_d;
            sign_q   <= SIGNED & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            if (mplier_q[0]) acc_q <= acc_q + pp_d;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_q <= SIGN;
          end
        end
        SIGN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            result_q <= s_lo_d;
            v_q      <= v_d;
            c_q      <= 1'b0;
            n_q      <= s_lo_d[WIDTH-1];
            z_q      <= (s_lo_d == '0);
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign v      = v_q;
  assign c      = c_q;
  assign n      = n_q;
  assign z      = z_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: stimulus pushes expected results with their
// due cycle; a negedge monitor pops and compares on every done pulse.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, v, c, n, z;
  logic [15:0] result;

  logic        u_start = 1'b0;
  logic [15:0] ua = '0, ub = '0;
  logic        u_busy, u_done, u_v, u_c, u_n, u_z;
  logic [15:0] u_result;

  mul_seq_ctrl #(.WIDTH(16), .SIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .v(v), .c(c), .n(n), .z(z));

  mul_seq_ctrl #(.WIDTH(16), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(u_start), .abort(1'b0), .a(ua), .b(ub),
    .busy(u_busy), .done(u_done), .result(u_result), .v(u_v), .c(u_c), .n(u_n), .z(u_z));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        v, n, z;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0, n_done = 0, n_push = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input bit push,
                       input logic [15:0] er, input logic ev, input logic en, input logic ez);
    exp_t e;
    a = ia; b = ib; start = 1'b1;
    if (push) begin
      e.res = er; e.v = ev; e.n = en; e.z = ez; e.cyc = cyc + 18;
      sb.push_back(e);
      n_push++;
    end
    step();
    start = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                        input logic [15:0] er, input logic ev, input logic en, input logic ez);
    issue(ia, ib, 1'b1, er, ev, en, ez);
    repeat (18) step();
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(result), 32'hDEAD);
      end else begin
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("v", 32'(v), 32'(e.v));
        check("c", 32'(c), 32'(0));
        check("n", 32'(n), 32'(e.n));
        check("z", 32'(z), 32'(e.z));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0, got;
    logic bad;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_flags_vcnz", {28'd0, v, c, n, z}, 32'h1);
    #19 rst_n = 1'b1;
    step();

    // 3*5 with busy window check
    issue(16'd3, 16'd5, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (busy !== 1'b1) bad = 1'b1;
      step();
    end
    check("busy_window", 32'(bad), 0);
    check("busy_after", 32'(busy), 0);

    run_op(16'hFFFD, 16'h0007, 16'hFFEB, 1'b0, 1'b1, 1'b0);
    run_op(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op(16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0);
    run_op(16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);

    // start held high through busy: back-to-back, operands change mid-op
    t0 = cyc;
    issue(16'd2, 16'd3, 1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    a = 16'd4; b = 16'd5;
    begin
      exp_t e;
      e.res = 16'h0014; e.v = 1'b0; e.n = 1'b0; e.z = 1'b0; e.cyc = t0 + 37;
      sb.push_back(e);
      n_push++;
    end
    repeat (19) step();
    start = 1'b0;
    repeat (19) step();
    check("b2b_idle", 32'(busy), 0);

    // abort in CALC iteration 7
    issue(16'd7, 16'd9, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (6) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_result_kept", 32'(result), 32'h0014);
    repeat (20) step();
    check("abort_result_late", 32'(result), 32'h0014);

    // abort and start together in IDLE
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 32'(busy), 0);
    repeat (20) step();

    // asynchronous reset during CALC
    issue(16'd5, 16'd5, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (4) step();
    check("pre_rst_busy", 32'(busy), 1);
    #4 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_result", 32'(result), 0);
    check("arst_z", 32'(z), 1);
    #1 rst_n = 1'b1;
    step();
    run_op(16'd2, 16'd2, 16'h0004, 1'b0, 1'b0, 1'b0);

    // unsigned variant
    ua = 16'hFFFF; ub = 16'h0002; u_start = 1'b1;
    t0 = cyc;
    step();
    u_start = 1'b0;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      if (u_done) begin
        got++;
        check("u_result", 32'(u_result), 32'hFFFE);
        check("u_flags_vcnz", {28'd0, u_v, u_c, u_n, u_z}, 32'hA);
        check("u_done_cycle", 32'(cyc), 32'(t0 + 18));
      end
      step();
    end
    check("u_done_count", 32'(got), 1);

    check("sb_empty", 32'(sb.size()), 0);
    check("done_total", 32'(n_done), 32'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
